// File: rtl/tqvp_gray_encoder_reader.sv
// tqvp_gray_encoder_reader: debounced Gray-coded absolute encoder reader with
// step tracking, wrap-around position count and invalid-jump detection.
module tqvp_gray_encoder_reader #(
    parameter int WIDTH    = 4,
    parameter int DEBOUNCE = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [3:0] address,
    input  logic       data_write,
    input  logic [7:0] data_in,
    output logic [7:0] data_out
);
    localparam logic [3:0] DB = 4'(DEBOUNCE);

    function automatic logic [WIDTH-1:0] g2b(input logic [WIDTH-1:0] g);
        logic [WIDTH-1:0] b;
        for (int i = 0; i < WIDTH; i++) b[i] = ^(g >> i);
        return b;
    endfunction

    logic             en, valid, dir, err, moved;
    logic [WIDTH-1:0] cand, stable, code, step;
    logic [3:0]       sc, sc_next;
    logic [7:0]       count, errcnt;
    logic             ctrl_wr, status_wr, en_eff, clr, accept, up, down, bad;

    assign code      = ui_in[WIDTH-1:0];
    assign ctrl_wr   = data_write && address == 4'h0;
    assign status_wr = data_write && address == 4'h3;
    assign en_eff    = ctrl_wr ? data_in[0] : en;
    assign clr       = ctrl_wr && data_in[1];
    assign sc_next   = (code != cand) ? 4'd1 : (sc == DB ? sc : sc + 4'd1);
    // With valid clear the first settled code only resynchronises the tracker
    assign accept    = en_eff && sc_next == DB && (code != stable || !valid);
    assign step      = g2b(code) - g2b(stable);
    assign up        = accept && valid && step == WIDTH'(1);
    assign down      = accept && valid && step == '1;
    assign bad       = accept && valid && !up && !down;
    assign uo_out    = count;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            en     <= 1'b0;
            valid  <= 1'b0;
            dir    <= 1'b0;
            err    <= 1'b0;
            moved  <= 1'b0;
            cand   <= '0;
            stable <= '0;
            sc     <= '0;
            count  <= '0;
            errcnt <= '0;
        end else begin
            en <= en_eff;
            if (!en_eff) begin
                sc    <= '0;
                valid <= 1'b0;
            end else begin
                cand <= code;
                sc   <= sc_next;
                if (accept) begin
                    stable <= code;
                    valid  <= 1'b1;
                end
            end
            if (up || down) dir <= up;
            count  <= clr ? 8'd0 : up ? count + 8'd1 : down ? count - 8'd1 : count;
            errcnt <= clr ? 8'd0 : (bad && errcnt != 8'hFF) ? errcnt + 8'd1 : errcnt;
            err    <= !clr && (bad || (err && !(status_wr && data_in[1])));
            moved  <= !clr && (up || down || (moved && !(status_wr && data_in[2])));
        end
    end

    always_comb begin
        data_out = 8'h00;
        case (address)
            4'h0: data_out = {7'b0, en};
            4'h1: data_out = {{(8-WIDTH){1'b0}}, g2b(stable)};
            4'h2: data_out = {{(8-WIDTH){1'b0}}, stable};
            4'h3: data_out = {4'b0, valid, moved, err, dir};
            4'h4: data_out = count;
            4'h5: data_out = errcnt;
            default: data_out = 8'h00;
        endcase
    end
endmodule

// File: tb/tb_tqvp_gray_encoder_reader.sv
// tb_tqvp_gray_encoder_reader: directed scenarios plus randomized encoder motion,
// register writes and resets, checked against a behavioural model.
module tb_tqvp_gray_encoder_reader;
    localparam int W = 4;
    localparam int D = 3;
    localparam int MASK = (1 << W) - 1;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] ui_in = 8'h00;
    logic [7:0] uo_out;
    logic [3:0] address = 4'h0;
    logic       data_write = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic [7:0] data_out;

    tqvp_gray_encoder_reader #(.WIDTH(W), .DEBOUNCE(D)) dut (
        .clk(clk), .rst_n(rst_n), .ui_in(ui_in), .uo_out(uo_out),
        .address(address), .data_write(data_write), .data_in(data_in), .data_out(data_out)
    );

    always #50 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Model: run = number of consecutive identical samples seen while enabled
    bit m_en, m_valid, m_dir, m_err, m_moved;
    int m_run, m_last, m_stable, m_count, m_errcnt;

    function automatic int bin(input int g);
        int b = 0;
        for (int x = g; x != 0; x = x >> 1) b = b ^ x;
        return b;
    endfunction

    function automatic logic [7:0] mreg(input int a);
        case (a)
            0: return {7'b0, m_en};
            1: return 8'(bin(m_stable));
            2: return 8'(m_stable);
            3: return {4'b0, m_valid, m_moved, m_err, m_dir};
            4: return 8'(m_count);
            5: return 8'(m_errcnt);
            default: return 8'h00;
        endcase
    endfunction

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %02h expected %02h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_edge();
        int  g, d;
        bit  cw, sw, en_eff, clr, acc;
        if (!rst_n) begin
            {m_en, m_valid, m_dir, m_err, m_moved} = '0;
            m_run = 0; m_last = 0; m_stable = 0; m_count = 0; m_errcnt = 0;
            return;
        end
        g      = int'(ui_in) & MASK;
        cw     = data_write && address == 4'h0;
        sw     = data_write && address == 4'h3;
        en_eff = cw ? data_in[0] : m_en;
        clr    = cw && data_in[1];
        acc    = 0;
        if (!en_eff) begin
            m_run = 0;
            m_valid = 0;
        end else begin
            m_run = (m_run > 0 && g == m_last) ? ((m_run + 1 > D) ? D : m_run + 1) : 1;
            m_last = g;
            acc = (m_run == D) && (g != m_stable || !m_valid);
        end
        if (sw && data_in[1]) m_err = 0;
        if (sw && data_in[2]) m_moved = 0;
        if (acc) begin
            d = (bin(g) - bin(m_stable)) & MASK;
            if (!m_valid) m_valid = 1;
            else if (d == 1) begin
                m_count = (m_count + 1) & 255; m_dir = 1; m_moved = 1;
            end else if (d == MASK) begin
                m_count = (m_count - 1) & 255; m_dir = 0; m_moved = 1;
            end else begin
                m_err = 1;
                if (m_errcnt < 255) m_errcnt++;
            end
            m_stable = g;
        end
        if (clr) begin
            m_count = 0; m_errcnt = 0; m_err = 0; m_moved = 0;
        end
        m_en = en_eff;
    endtask

    task automatic tick(input logic [7:0] u, input logic wr, input logic [3:0] a, input logic [7:0] d);
        ui_in = u; data_write = wr; address = a; data_in = d;
        model_edge();
        @(posedge clk);
        #1;
        data_write = 1'b0;
        check("uo_out", uo_out, 8'(m_count));
    endtask

    task automatic hold(input logic [7:0] u, input int n);
        repeat (n) tick(u, 1'b0, 4'h0, 8'h00);
    endtask

    task automatic check_regs();
        for (int a = 0; a < 16; a++) begin
            address = 4'(a);
            #1;
            check($sformatf("reg%0h", a), data_out, mreg(a));
        end
    endtask

    task automatic read_chk(input string tag, input logic [3:0] a, input logic [7:0] exp);
        address = a;
        #1;
        check(tag, data_out, exp);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL timeout: run did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        int b, left, r;
        logic [7:0] u, wd;
        // Reset state
        rst_n = 1'b0;
        tick(8'h00, 1'b0, 4'h0, 8'h00);
        rst_n = 1'b1;
        check_regs();
        check("t1_uo", uo_out, 8'h00);
        // Up steps 0,1,3,2 after a resync on the first code
        tick(8'h00, 1'b1, 4'h0, 8'h01);
        hold(8'h00, 3); hold(8'h01, 4); hold(8'h03, 4); hold(8'h02, 4);
        check_regs();
        check("t2_count", uo_out, 8'h03);
        read_chk("t2_pos", 4'h1, 8'h03);
        read_chk("t2_status", 4'h3, 8'h0D);
        // COUNT 0xFF, resync at binary 15, wrap to 0
        tick(8'h00, 1'b1, 4'h0, 8'h03);
        hold(8'h03, 4);
        check("t3_ff", uo_out, 8'hFF);
        tick(8'h00, 1'b1, 4'h0, 8'h00);
        tick(8'h08, 1'b1, 4'h0, 8'h01);
        hold(8'h08, 3);
        check("t3_resync_count", uo_out, 8'hFF);
        read_chk("t3_resync_pos", 4'h1, 8'h0F);
        hold(8'h00, 4);
        check_regs();
        check("t3_wrap_count", uo_out, 8'h00);
        read_chk("t3_wrap_pos", 4'h1, 8'h00);
        read_chk("t3_dir", 4'h3, 8'h0D);
        // Short glitch is ignored
        hold(8'h01, 4);
        check("t4_before", uo_out, 8'h01);
        hold(8'h03, 2); hold(8'h01, 4);
        check_regs();
        check("t4_count", uo_out, 8'h01);
        // Invalid jump from binary 0 to binary 3
        hold(8'h00, 4); hold(8'h02, 4);
        check_regs();
        read_chk("t5_errcnt", 4'h5, 8'h01);
        read_chk("t5_raw", 4'h2, 8'h02);
        check("t5_count", uo_out, 8'h00);
        // CLR on the accept edge of a +1 step
        hold(8'h06, 2);
        tick(8'h06, 1'b1, 4'h0, 8'h03);
        check_regs();
        check("t6_count", uo_out, 8'h00);
        read_chk("t6_status", 4'h3, 8'h09);
        read_chk("t6_raw", 4'h2, 8'h06);
        hold(8'h07, 4); hold(8'h00, 4);
        read_chk("t6_sticky", 4'h3, 8'h0F);
        tick(8'h00, 1'b1, 4'h3, 8'h06);
        read_chk("t6_stclr", 4'h3, 8'h09);
        check_regs();
        // Randomized motion, glitches, writes and resets
        b = bin(0);
        left = 0;
        for (int i = 0; i < 3000; i++) begin
            if (left == 0) begin
                r = $urandom_range(0, 9);
                if (r < 4) b = (b + 1) & MASK;
                else if (r < 7) b = (b - 1) & MASK;
                else if (r < 9) b = $urandom_range(0, MASK);
                left = $urandom_range(1, 6);
            end
            left--;
            u = (8'($urandom) & 8'hF0) | 8'(b ^ (b >> 1));
            r = $urandom_range(0, 299);
            if (r == 0) begin
                rst_n = 1'b0;
                tick(u, 1'b0, 4'h0, 8'h00);
                rst_n = 1'b1;
            end else if (r < 12) begin
                wd = {6'b0, 1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 4) != 0)};
                tick(u, 1'b1, 4'h0, wd);
            end else if (r < 24) begin
                tick(u, 1'b1, 4'h3, 8'($urandom));
            end else if (r < 30) begin
                tick(u, 1'b1, 4'($urandom_range(4, 15)), 8'($urandom));
            end else if (!m_en) begin
                tick(u, 1'b1, 4'h0, 8'h01);
            end else begin
                tick(u, 1'b0, 4'h0, 8'h00);
            end
            if (i % 8 == 0) check_regs();
        end
        check_regs();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
